// File: rtl/rv32e_pkg.sv
// ---------------------------------------------------------------------------
// rv32e_pkg
// Shared types and constants for the rv32e instruction prefetch stage.
//   XLEN          : architectural register / address width
//   RV32E_NOP     : canonical NOP (addi x0, x0, 0), shown on an empty head
//   PC_STEP       : sequential fetch increment (one 32-bit word)
//   fetch_entry_t : one prefetch queue entry, {pc, instr}, pc in the MSBs
// ---------------------------------------------------------------------------
package rv32e_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] RV32E_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/rv32e_sync_fifo.sv
// ---------------------------------------------------------------------------
// rv32e_sync_fifo
// Small synchronous FIFO with a combinational head read.
// Ports:
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-low reset
//   push          in   write wdata this cycle (caller guarantees !full || pop)
//   pop           in   discard the head this cycle (caller guarantees !empty)
//   flush         in   empty the FIFO; overrides push and pop
//   wdata         in   WIDTH-bit entry to write
//   rdata         out  WIDTH-bit head entry (meaningless when empty)
//   count         out  number of stored entries, 0..DEPTH
//   full / empty  out  count == DEPTH / count == 0
// DEPTH must be a power of two so the pointers wrap naturally.
// Simultaneous push and pop is legal when full: the slot being written is
// the one being popped, and the head is read before the edge.
// ---------------------------------------------------------------------------
module rv32e_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset: entries are only observable through count.
  always_ff @(posedge clk) begin
    if (reset && do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/rv32e_prefetch.sv
// ---------------------------------------------------------------------------
// rv32e_prefetch
// Instruction prefetch between the core fetch port and a combinational ROM.
// Owns fetch_pc, captures {pc, instr} pairs into a FIFO and hands them to
// decode. A redirect flushes the FIFO and restarts fetch at a new PC.
// Parameters: DEPTH (power of two, >= 2), RESET_PC (word aligned).
// Ports:
//   clk, reset (sync, active-low)
//   program_addr_bus  out  fetch address, always equal to fetch_pc
//   program_data_bus  in   ROM word for program_addr_bus, same cycle
//   redirect_valid/pc in   flush and restart at {redirect_pc[31:2], 2'b00}
//   instr_valid/data/pc out head of queue (NOP / 0 when not valid)
//   instr_ready       in   decode accepts the head this cycle
// Optional build macro RV32E_PREFETCH_STATS_EN adds stat_fetches (pushes)
// and stat_flushes (redirect cycles), 32-bit wrapping counters.
// Handshake: an entry transfers on any cycle with instr_valid && instr_ready;
// while instr_valid=1 and instr_ready=0 the head outputs hold steady.
// Fill state (EMPTY / PARTIAL / FULL) is implied by the FIFO count.
// ---------------------------------------------------------------------------
module rv32e_prefetch
  import rv32e_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] program_addr_bus,
  input  logic [31:0] program_data_bus,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
`ifdef RV32E_PREFETCH_STATS_EN
  ,
  output logic [31:0] stat_fetches,
  output logic [31:0] stat_flushes
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]  fetch_pc;
  logic         push;
  logic         pop;
  fetch_entry_t wr_entry;
  fetch_entry_t head;
  logic [CW-1:0] fifo_count;
  logic         fifo_full;
  logic         fifo_empty;
  logic         unused_bits;

  // Low PC bits of a redirect are dropped; the count is implied by the flags.
  assign unused_bits = ^{redirect_pc[1:0], fifo_count};

  assign pop  = instr_valid && instr_ready;
  // A pop frees the head slot in the same edge, so a full queue keeps fetching.
  assign push = !redirect_valid && (!fifo_full || pop);

  assign wr_entry = '{pc: fetch_pc, instr: program_data_bus};

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= align_pc(redirect_pc);
    end else if (push) begin
      fetch_pc <= fetch_pc + PC_STEP;
    end
  end

  rv32e_sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wr_entry),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign program_addr_bus = fetch_pc;
  assign instr_valid      = !fifo_empty;
  assign instr_data       = instr_valid ? head.instr : RV32E_NOP;
  assign instr_pc         = instr_valid ? head.pc    : 32'h0000_0000;

`ifdef RV32E_PREFETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_fetches <= '0;
      stat_flushes <= '0;
    end else begin
      if (push)           stat_fetches <= stat_fetches + 32'd1;
      if (redirect_valid) stat_flushes <= stat_flushes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rv32e_prefetch.sv
// ---------------------------------------------------------------------------
// tb_rv32e_prefetch
// Bench for rv32e_prefetch. dut0 uses RESET_PC=0, dut1 uses
// RESET_PC=32'hFFFF_FFF8 to exercise PC wrap. Both read a ROM model where
// the word at pc holds 0x100 + pc/4. Expected {pc, instr} pairs are queued
// when stimulus is driven and popped on each accepted handshake.
// ---------------------------------------------------------------------------
module tb_rv32e_prefetch;
  import rv32e_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_ready;
  logic [31:0] program_addr_bus;
  logic [31:0] program_data_bus;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;

  logic        redirect2_valid;
  logic [31:0] redirect2_pc;
  logic        ready2;
  logic [31:0] addr2;
  logic [31:0] data2;
  logic        valid2;
  logic [31:0] idata2;
  logic [31:0] ipc2;

`ifdef RV32E_PREFETCH_STATS_EN
  logic [31:0] stat_fetches, stat_flushes, stat_fetches2, stat_flushes2;
`endif

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    return 32'h100 + (pc >> 2);
  endfunction

  assign program_data_bus = rom_word(program_addr_bus);
  assign data2            = rom_word(addr2);

  rv32e_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut0 (
    .clk              (clk),
    .reset            (reset),
    .program_addr_bus (program_addr_bus),
    .program_data_bus (program_data_bus),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .instr_valid      (instr_valid),
    .instr_data       (instr_data),
    .instr_pc         (instr_pc),
    .instr_ready      (instr_ready)
`ifdef RV32E_PREFETCH_STATS_EN
    ,
    .stat_fetches     (stat_fetches),
    .stat_flushes     (stat_flushes)
`endif
  );

  rv32e_prefetch #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut1 (
    .clk              (clk),
    .reset            (reset),
    .program_addr_bus (addr2),
    .program_data_bus (data2),
    .redirect_valid   (redirect2_valid),
    .redirect_pc      (redirect2_pc),
    .instr_valid      (valid2),
    .instr_data       (idata2),
    .instr_pc         (ipc2),
    .instr_ready      (ready2)
`ifdef RV32E_PREFETCH_STATS_EN
    ,
    .stat_fetches     (stat_fetches2),
    .stat_flushes     (stat_flushes2)
`endif
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboards ----------------
  logic [63:0] exp_q[$];
  logic [63:0] exp2_q[$];
  logic [63:0] e0, e1;

  task automatic push_run(input int which, input logic [31:0] start, input int n);
    logic [31:0] pc;
    pc = start;
    for (int i = 0; i < n; i++) begin
      if (which == 0) exp_q.push_back({pc, rom_word(pc)});
      else            exp2_q.push_back({pc, rom_word(pc)});
      pc = pc + 32'd4;
    end
  endtask

  // Handshakes in a redirect cycle are accepted but belong to the old stream.
  always @(negedge clk) begin
    if (reset && !redirect_valid && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        check("sb0_unexpected_entry_qsize", 32'(exp_q.size()), 32'd1);
      end else begin
        e0 = exp_q.pop_front();
        check("sb0_pc", instr_pc, e0[63:32]);
        check("sb0_data", instr_data, e0[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (reset && valid2 && ready2) begin
      if (exp2_q.size() == 0) begin
        check("sb1_unexpected_entry_qsize", 32'(exp2_q.size()), 32'd1);
      end else begin
        e1 = exp2_q.pop_front();
        check("sb1_pc", ipc2, e1[63:32]);
        check("sb1_data", idata2, e1[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain0(input int budget, output int cycles);
    instr_ready = 1'b1;
    cycles = 0;
    while (exp_q.size() != 0 && cycles < budget) begin
      tick();
      cycles++;
    end
    instr_ready = 1'b0;
    check("drain0_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic drain1(input int budget, output int cycles);
    ready2 = 1'b1;
    cycles = 0;
    while (exp2_q.size() != 0 && cycles < budget) begin
      tick();
      cycles++;
    end
    ready2 = 1'b0;
    check("drain1_left", 32'(exp2_q.size()), 32'd0);
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
  endtask

  task automatic check_reset_vals(input string tag);
    @(negedge clk);
    check({tag, "_addr"},  program_addr_bus, 32'h0000_0000);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_data"},  instr_data, RV32E_NOP);
    check({tag, "_pc"},    instr_pc, 32'h0000_0000);
    check({tag, "_addr2"}, addr2, 32'hFFFF_FFF8);
  endtask

  // ---------------- main sequence ----------------
  int cyc;

  initial begin
    reset           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    instr_ready     = 1'b0;
    redirect2_valid = 1'b0;
    redirect2_pc    = '0;
    ready2          = 1'b0;
    repeat (3) tick();
    check_reset_vals("por");
    tick();

    // Reset release with decode ready: first entry valid one cycle later.
    push_run(0, 32'h0, 3);
    reset       = 1'b1;
    instr_ready = 1'b1;
    @(negedge clk);
    check("rel_valid_before_edge", 32'(instr_valid), 32'd0);
    tick();
    @(negedge clk);
    check("rel_first_valid", 32'(instr_valid), 32'd1);
    check("rel_first_pc", instr_pc, 32'h0);
    check("rel_first_data", instr_data, 32'h100);
    drain0(20, cyc);

    // Reset mid-stream discards everything.
    reset = 1'b0;
    tick();
    check_reset_vals("mid_reset");
    tick();

    // Stall: decode not ready, queue fills to DEPTH and fetch holds.
    reset = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    check("stall_addr", program_addr_bus, 32'h10);
    check("stall_valid", 32'(instr_valid), 32'd1);
    check("stall_head_pc", instr_pc, 32'h0);
    tick();
    @(negedge clk);
    check("stall_addr_hold", program_addr_bus, 32'h10);
    check("stall_head_pc_hold", instr_pc, 32'h0);
    check("stall_head_data_hold", instr_data, 32'h100);
    check("wrap_full_addr", addr2, 32'h0000_0008);
    tick();
    push_run(0, 32'h0, 5);
    drain0(20, cyc);
    check("stall_drain_cycles", 32'(cyc), 32'd5);
    push_run(1, 32'hFFFF_FFF8, 4);
    drain1(20, cyc);
    check("wrap_drain_cycles", 32'(cyc), 32'd4);

    // Redirect while full: no stale entries, target valid two cycles later.
    repeat (6) tick();
    redirect(32'h40);
    @(negedge clk);
    check("redir_valid_n1", 32'(instr_valid), 32'd0);
    check("redir_addr_n1", program_addr_bus, 32'h40);
    check("redir_data_nop", instr_data, RV32E_NOP);
    push_run(0, 32'h40, 3);
    tick();
    @(negedge clk);
    check("redir_valid_n2", 32'(instr_valid), 32'd1);
    check("redir_pc_n2", instr_pc, 32'h40);
    tick();
    drain0(20, cyc);

    // Unaligned redirect target is forced to a word boundary.
    redirect(32'h43);
    @(negedge clk);
    check("unaligned_addr", program_addr_bus, 32'h40);
    push_run(0, 32'h40, 2);
    tick();
    drain0(20, cyc);

    // Back-to-back redirects: the last one wins.
    redirect(32'h80);
    redirect(32'hC0);
    @(negedge clk);
    check("b2b_addr", program_addr_bus, 32'hC0);
    check("b2b_valid", 32'(instr_valid), 32'd0);
    push_run(0, 32'hC0, 2);
    tick();
    drain0(20, cyc);

    // Fresh reset, then 6 pushes and 2 redirect cycles.
    reset = 1'b0;
    tick();
    check_reset_vals("final_reset");
`ifdef RV32E_PREFETCH_STATS_EN
    check("stat_fetches_reset", stat_fetches, 32'd0);
    check("stat_flushes_reset", stat_flushes, 32'd0);
`endif
    tick();
    reset = 1'b1;
    repeat (6) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    repeat (2) tick();
    redirect_valid = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("post_flush_addr", program_addr_bus, 32'h208);
    check("post_flush_head_pc", instr_pc, 32'h200);
`ifdef RV32E_PREFETCH_STATS_EN
    check("stat_fetches", stat_fetches, 32'd6);
    check("stat_flushes", stat_flushes, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
